inst_rom: RTL and testbench
===========================

INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, sets storage depth to 2^DEPTH_LOG2 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rom_ce_i  input  1  fetch enable from the core.
REQ-005 rom_addr_i  input  32  byte address of the instruction fetch.
REQ-006 rom_data_o  output  32  instruction word returned to the core.
REQ-007 ld_start  input  1  pulse; opens a load session.
REQ-008 ld_addr_i  input  DEPTH_LOG2  starting word index for the session, sampled with ld_start.
REQ-009 ld_byte_valid  input  1  loader byte valid.
REQ-010 ld_byte  input  8  loader byte data.
REQ-011 ld_end  input  1  pulse; closes the load session.
REQ-012 ld_byte_ready  output  1  block accepts a byte this cycle.
REQ-013 ld_busy  output  1  load session active.
REQ-014 ld_count  output  16  words written in the current or last session.
REQ-015 ld_overflow  output  1  sticky: write pointer wrapped during the session.

Function
REQ-016 The fetch path SHALL be combinational: rom_data_o = 0 when rom_ce_i=0, ld_busy=1, or rom_addr_i[31:DEPTH_LOG2+2] != 0; otherwise mem[rom_addr_i[DEPTH_LOG2+1:2]]; rom_addr_i[1:0] is ignored.
REQ-017 The loader FSM SHALL have states IDLE, LOAD and WRITE; ld_busy=1 in LOAD and WRITE; ld_byte_ready=1 only in LOAD.
REQ-018 IDLE: on ld_start SHALL go to LOAD, setting ptr=ld_addr_i, byte_cnt=0, ld_count=0, ld_overflow=0, end_pending=0; ld_end and ld_byte_valid SHALL be ignored.
REQ-019 LOAD: a byte SHALL be accepted when ld_byte_valid=1; byte k (k=0..3) goes to word bits [31-8k:24-8k] (big-endian); byte_cnt increments.
REQ-020 Accepting the 4th byte SHALL move the FSM to WRITE and reset byte_cnt to 0.
REQ-021 WRITE (exactly one cycle): mem[ptr] SHALL be written with the assembled word; ptr increments modulo 2^DEPTH_LOG2; ld_count increments, saturating at 0xFFFF; the assembly register clears.
REQ-022 WRITE: if ptr = 2^DEPTH_LOG2-1 the increment wraps ptr to 0 and ld_overflow SHALL be set.
REQ-023 ld_end in LOAD with byte_cnt=0 and no byte accepted that cycle SHALL return the FSM to IDLE with no write.
REQ-024 ld_end in LOAD with a partial word SHALL go to WRITE; unfilled low bytes are written as 0; the FSM then returns to IDLE.
REQ-025 ld_end in the same cycle as an accepted byte: the byte SHALL be accepted first, then ld_end applies to the resulting byte_cnt per REQ-023/024.
REQ-026 If that byte completes the word, the word SHALL be written and the FSM SHALL then go to IDLE.
REQ-027 ld_end in WRITE SHALL set end_pending, and the FSM SHALL go to IDLE after the write.
REQ-028 ld_start outside IDLE SHALL be ignored.
REQ-029 ld_count and ld_overflow SHALL hold their values in IDLE until the next ld_start.

Reset
REQ-030 On rst=1 at a clock edge: FSM=IDLE; ptr, byte_cnt, end_pending and the assembly register = 0; ld_count=0; ld_overflow=0; ld_busy=0; ld_byte_ready=0.
REQ-031 Reset SHALL abort an in-progress session with no partial write; memory contents SHALL NOT be cleared.
REQ-032 Reset SHALL have priority over all other inputs.

Verification
REQ-033 Load: ld_start with ld_addr_i=5, bytes 34 02 00 0A, ld_end -> mem[5]=0x3402000A, ld_count=1; fetch at addr 0x14 with rom_ce_i=1 returns 0x3402000A.
REQ-034 Partial load: bytes AA BB then ld_end -> mem[ptr]=0xAABB0000, FSM returns to IDLE, ld_count=1.
REQ-035 Wrap: ld_addr_i=1023 (default depth), 8 bytes -> words at 1023 and 0, ld_overflow=1, ld_count=2.
REQ-036 Fetch gating: rom_ce_i=0 or ld_busy=1 -> rom_data_o=0; rom_addr_i=0x00001000 -> 0.
REQ-037 Reset mid-load: 3 bytes, then rst -> no memory change; ld_busy=0; ld_count=0; prior contents readable.
REQ-038 Collision: 4th byte together with ld_end -> word written once; IDLE reached two cycles later; ld_start during WRITE ignored.

Source files
------------

// File: rtl/inst_rom.sv
// Instruction ROM with a combinational fetch port and a byte-stream loader.
// The loader packs big-endian bytes into words and writes them sequentially.
module inst_rom #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_ce_i,
   input  logic [31:0]           rom_addr_i,
   output logic [31:0]           rom_data_o,
   input  logic                  ld_start,
   input  logic [DEPTH_LOG2-1:0] ld_addr_i,
   input  logic                  ld_byte_valid,
   input  logic [7:0]            ld_byte,
   input  logic                  ld_end,
   output logic                  ld_byte_ready,
   output logic                  ld_busy,
   output logic [15:0]           ld_count,
   output logic                  ld_overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE
   } state_t;

   state_t                state;
   logic [DEPTH_LOG2-1:0] ptr;
   logic [1:0]            byte_cnt;
   logic [31:0]           asm_word;
   logic                  end_pending;

   logic [31:0] mem [DEPTH];

   logic                  byte_take;
   logic                  word_full;
   logic                  has_bytes;
   logic [31:0]           asm_next;
   logic                  addr_in_range;
   logic [DEPTH_LOG2-1:0] fetch_idx;
   logic                  unused_addr_bits;

   // Byte lanes are ignored: fetches are word aligned.
   assign unused_addr_bits = ^rom_addr_i[1:0];

   // Merge the incoming byte into its big-endian lane of the assembly word.
   always_comb begin
      byte_take = (state == LOAD) && ld_byte_valid;
      word_full = byte_take && (byte_cnt == 2'd3);
      has_bytes = byte_take || (byte_cnt != 2'd0);
      asm_next  = asm_word;
      if (byte_take) begin
         unique case (byte_cnt)
            2'd0: asm_next[31:24] = ld_byte;
            2'd1: asm_next[23:16] = ld_byte;
            2'd2: asm_next[15:8]  = ld_byte;
            2'd3: asm_next[7:0]   = ld_byte;
            default: asm_next = asm_word;
         endcase
      end
   end

   // Loader FSM; busy/ready are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= '0;
         byte_cnt      <= 2'd0;
         asm_word      <= 32'd0;
         end_pending   <= 1'b0;
         ld_count      <= 16'd0;
         ld_overflow   <= 1'b0;
         ld_busy       <= 1'b0;
         ld_byte_ready <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ld_start) begin
                  state         <= LOAD;
                  ptr           <= ld_addr_i;
                  byte_cnt      <= 2'd0;
                  asm_word      <= 32'd0;
                  end_pending   <= 1'b0;
                  ld_count      <= 16'd0;
                  ld_overflow   <= 1'b0;
                  ld_busy       <= 1'b1;
                  ld_byte_ready <= 1'b1;
               end
            end
            LOAD: begin
               asm_word <= asm_next;
               if (byte_take) begin
                  byte_cnt <= byte_cnt + 2'd1;
               end
               if (word_full) begin
                  state         <= WRITE;
                  ld_byte_ready <= 1'b0;
                  end_pending   <= ld_end;
               end else if (ld_end && has_bytes) begin
                  state         <= WRITE;
                  ld_byte_ready <= 1'b0;
                  end_pending   <= 1'b1;
                  byte_cnt      <= 2'd0;
               end else if (ld_end) begin
                  state         <= IDLE;
                  ld_busy       <= 1'b0;
                  ld_byte_ready <= 1'b0;
               end
            end
            WRITE: begin
               ptr      <= ptr + PTR_ONE;
               asm_word <= 32'd0;
               if (ptr == PTR_MAX) begin
                  ld_overflow <= 1'b1;
               end
               if (ld_count != 16'hFFFF) begin
                  ld_count <= ld_count + 16'd1;
               end
               if (end_pending || ld_end) begin
                  state         <= IDLE;
                  end_pending   <= 1'b0;
                  ld_busy       <= 1'b0;
                  ld_byte_ready <= 1'b0;
               end else begin
                  state         <= LOAD;
                  ld_byte_ready <= 1'b1;
               end
            end
            default: begin
               state         <= IDLE;
               ld_busy       <= 1'b0;
               ld_byte_ready <= 1'b0;
            end
         endcase
      end
   end

   // Storage write; contents survive reset, reset only blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && state == WRITE) begin
         mem[ptr] <= asm_word;
      end
   end

   // Combinational fetch, gated off while loading or out of range.
   always_comb begin
      addr_in_range = (rom_addr_i[31:DEPTH_LOG2+2] == '0);
      fetch_idx     = rom_addr_i[DEPTH_LOG2+1:2];
      rom_data_o    = 32'd0;
      if (rom_ce_i && !ld_busy && addr_in_range) begin
         rom_data_o = mem[fetch_idx];
      end
   end

endmodule

// File: tb/tb_inst_rom.sv
// Bench for inst_rom: directed scenarios plus random load sessions
// checked against a word-level model of the ROM contents.
module tb_inst_rom;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        ld_start;
   logic [9:0]  ld_addr_i;
   logic        ld_byte_valid;
   logic [7:0]  ld_byte;
   logic        ld_end;
   logic        ld_byte_ready;
   logic        ld_busy;
   logic [15:0] ld_count;
   logic        ld_overflow;

   int total = 0;
   int bad   = 0;

   logic [31:0] model_mem [1024];
   bit          known [1024];

   always #5 clk = ~clk;

   inst_rom #(.DEPTH_LOG2(10)) dut (
      .clk           (clk),
      .rst           (rst),
      .rom_ce_i      (rom_ce_i),
      .rom_addr_i    (rom_addr_i),
      .rom_data_o    (rom_data_o),
      .ld_start      (ld_start),
      .ld_addr_i     (ld_addr_i),
      .ld_byte_valid (ld_byte_valid),
      .ld_byte       (ld_byte),
      .ld_end        (ld_end),
      .ld_byte_ready (ld_byte_ready),
      .ld_busy       (ld_busy),
      .ld_count      (ld_count),
      .ld_overflow   (ld_overflow)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session(input logic [9:0] a);
      ld_start  = 1'b1;
      ld_addr_i = a;
      tick();
      ld_start  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_end);
      bit r;
      int n;
      r = 1'b0;
      n = 0;
      ld_byte_valid = 1'b1;
      ld_byte       = b;
      while (!r && n < 20) begin
         r      = ld_byte_ready;
         ld_end = with_end & r;
         tick();
         n++;
      end
      ld_byte_valid = 1'b0;
      ld_end        = 1'b0;
      total++;
      if (!r) begin
         bad++;
         $display("FAIL byte_handshake: ready=%0b required=1", r);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (ld_busy && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (ld_busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_timeout: busy=%0b required=0", ld_busy);
      end
   endtask

   task automatic end_session();
      ld_end = 1'b1;
      tick();
      ld_end = 1'b0;
      wait_idle();
   endtask

   // Model: bytes chunk into big-endian words at consecutive addresses.
   task automatic model_load(input logic [9:0] a, input logic [7:0] q[$],
                             output int cnt, output bit ovf);
      int nw;
      logic [31:0] w;
      logic [9:0] wa;
      nw  = (q.size() + 3) / 4;
      ovf = 1'b0;
      for (int i = 0; i < nw; i++) begin
         w = 32'd0;
         for (int k = 0; k < 4; k++) begin
            if (4 * i + k < q.size()) w[31-8*k -: 8] = q[4*i+k];
         end
         wa = a + 10'(i);
         model_mem[wa] = w;
         known[wa]     = 1'b1;
         if (wa == 10'd1023) ovf = 1'b1;
      end
      cnt = nw;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (ld_busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy: got=%0b required=0", ld_busy);
      end
      total++;
      if (ld_byte_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready: got=%0b required=0", ld_byte_ready);
      end
      total++;
      if (ld_count !== 16'd0) begin
         bad++; $display("FAIL reset_count: got=%0d required=0", ld_count);
      end
      total++;
      if (ld_overflow !== 1'b0) begin
         bad++; $display("FAIL reset_ovf: got=%0b required=0", ld_overflow);
      end
      ld_start  = 1'b1;
      ld_addr_i = 10'd3;
      tick();
      ld_start  = 1'b0;
      total++;
      if (ld_busy !== 1'b0) begin
         bad++; $display("FAIL reset_priority: busy=%0b required=0", ld_busy);
      end
      rst = 1'b0;
      tick();
      total++;
      if (rom_data_o !== 32'd0) begin
         bad++; $display("FAIL reset_fetch_off: got=%h required=0", rom_data_o);
      end
   endtask

   task automatic test_load();
      logic [7:0] q[$];
      int cnt;
      bit ovf;
      q = '{8'h34, 8'h02, 8'h00, 8'h0A};
      start_session(10'd5);
      foreach (q[i]) send_byte(q[i], 1'b0);
      end_session();
      model_load(10'd5, q, cnt, ovf);
      total++;
      if (ld_count !== 16'd1) begin
         bad++; $display("FAIL load_count: got=%0d required=1", ld_count);
      end
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h14;
      #1;
      total++;
      if (rom_data_o !== 32'h3402000A) begin
         bad++; $display("FAIL load_fetch: got=%h required=3402000a", rom_data_o);
      end
      rom_addr_i = 32'h17;
      #1;
      total++;
      if (rom_data_o !== 32'h3402000A) begin
         bad++; $display("FAIL load_fetch_lane: got=%h required=3402000a", rom_data_o);
      end
   endtask

   task automatic test_partial();
      logic [7:0] q[$];
      int cnt;
      bit ovf;
      q = '{8'hAA, 8'hBB};
      start_session(10'd9);
      foreach (q[i]) send_byte(q[i], 1'b0);
      end_session();
      model_load(10'd9, q, cnt, ovf);
      total++;
      if (ld_count !== 16'd1) begin
         bad++; $display("FAIL partial_count: got=%0d required=1", ld_count);
      end
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h24;
      #1;
      total++;
      if (rom_data_o !== 32'hAABB0000) begin
         bad++; $display("FAIL partial_word: got=%h required=aabb0000", rom_data_o);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] q[$];
      int cnt;
      bit ovf;
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      start_session(10'd1023);
      foreach (q[i]) send_byte(q[i], 1'b0);
      end_session();
      model_load(10'd1023, q, cnt, ovf);
      total++;
      if (ld_count !== 16'd2) begin
         bad++; $display("FAIL wrap_count: got=%0d required=2", ld_count);
      end
      total++;
      if (ld_overflow !== 1'b1) begin
         bad++; $display("FAIL wrap_ovf: got=%0b required=1", ld_overflow);
      end
      rom_ce_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         logic [9:0] wa;
         wa = (i == 0) ? 10'd1023 : 10'd0;
         rom_addr_i = {20'd0, wa, 2'b00};
         #1;
         total++;
         if (rom_data_o !== model_mem[wa]) begin
            bad++;
            $display("FAIL wrap_word[%0d]: got=%h required=%h", wa, rom_data_o, model_mem[wa]);
         end
      end
   endtask

   task automatic test_fetch_gating();
      rom_ce_i   = 1'b0;
      rom_addr_i = 32'h14;
      #1;
      total++;
      if (rom_data_o !== 32'd0) begin
         bad++; $display("FAIL gate_ce: got=%h required=0", rom_data_o);
      end
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h00001000;
      #1;
      total++;
      if (rom_data_o !== 32'd0) begin
         bad++; $display("FAIL gate_range: got=%h required=0", rom_data_o);
      end
      rom_addr_i = 32'hFFFF_FFFC;
      #1;
      total++;
      if (rom_data_o !== 32'd0) begin
         bad++; $display("FAIL gate_range_hi: got=%h required=0", rom_data_o);
      end
      start_session(10'd100);
      rom_addr_i = 32'h14;
      #1;
      total++;
      if (rom_data_o !== 32'd0) begin
         bad++; $display("FAIL gate_busy: got=%h required=0", rom_data_o);
      end
      end_session();
      total++;
      if (ld_count !== 16'd0) begin
         bad++; $display("FAIL empty_count: got=%0d required=0", ld_count);
      end
      total++;
      if (ld_overflow !== 1'b0) begin
         bad++; $display("FAIL empty_ovf_cleared: got=%0b required=0", ld_overflow);
      end
   endtask

   task automatic test_reset_midload();
      start_session(10'd5);
      for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (ld_busy !== 1'b0) begin
         bad++; $display("FAIL midrst_busy: got=%0b required=0", ld_busy);
      end
      total++;
      if (ld_count !== 16'd0) begin
         bad++; $display("FAIL midrst_count: got=%0d required=0", ld_count);
      end
      tick();
      tick();
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h14;
      #1;
      total++;
      if (rom_data_o !== model_mem[5]) begin
         bad++; $display("FAIL midrst_keep: got=%h required=%h", rom_data_o, model_mem[5]);
      end
      rom_addr_i = 32'h24;
      #1;
      total++;
      if (rom_data_o !== model_mem[9]) begin
         bad++; $display("FAIL midrst_keep9: got=%h required=%h", rom_data_o, model_mem[9]);
      end
   endtask

   task automatic test_collision();
      logic [7:0] q[$];
      int cnt;
      bit ovf;
      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      start_session(10'd20);
      for (int i = 0; i < 3; i++) send_byte(q[i], 1'b0);
      send_byte(q[3], 1'b1);
      model_load(10'd20, q, cnt, ovf);
      total++;
      if (ld_busy !== 1'b1 || ld_byte_ready !== 1'b0) begin
         bad++;
         $display("FAIL coll_write_state: busy=%0b ready=%0b required busy=1 ready=0",
                  ld_busy, ld_byte_ready);
      end
      ld_start  = 1'b1;
      ld_addr_i = 10'd50;
      tick();
      ld_start  = 1'b0;
      total++;
      if (ld_busy !== 1'b0) begin
         bad++; $display("FAIL coll_idle: busy=%0b required=0", ld_busy);
      end
      total++;
      if (ld_count !== 16'd1) begin
         bad++; $display("FAIL coll_count: got=%0d required=1", ld_count);
      end
      tick();
      total++;
      if (ld_busy !== 1'b0) begin
         bad++; $display("FAIL coll_start_ignored: busy=%0b required=0", ld_busy);
      end
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h50;
      #1;
      total++;
      if (rom_data_o !== 32'h11223344) begin
         bad++; $display("FAIL coll_word: got=%h required=11223344", rom_data_o);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 12; s++) begin
         logic [7:0] q[$];
         logic [9:0] a;
         int n;
         int cnt;
         bit ovf;
         bit end_with_last;
         q.delete();
         a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(1018, 1023))
                                         : 10'($urandom);
         n = $urandom_range(0, 13);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         end_with_last = (n > 0) && ($urandom_range(0, 1) == 1);
         start_session(a);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(q[i], end_with_last && (i == n - 1));
         end
         if (end_with_last) wait_idle();
         else end_session();
         model_load(a, q, cnt, ovf);
         total++;
         if (ld_count !== 16'(cnt)) begin
            bad++; $display("FAIL rnd%0d_count: got=%0d required=%0d", s, ld_count, cnt);
         end
         total++;
         if (ld_overflow !== ovf) begin
            bad++; $display("FAIL rnd%0d_ovf: got=%0b required=%0b", s, ld_overflow, ovf);
         end
         rom_ce_i = 1'b1;
         for (int i = 0; i < 8; i++) begin
            logic [9:0] ra;
            ra = (i < cnt) ? a + 10'(i) : 10'($urandom);
            if (known[ra]) begin
               rom_addr_i = {20'd0, ra, 2'($urandom)};
               #1;
               total++;
               if (rom_data_o !== model_mem[ra]) begin
                  bad++;
                  $display("FAIL rnd%0d_word[%0d]: got=%h required=%h",
                           s, ra, rom_data_o, model_mem[ra]);
               end
            end
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      rom_ce_i      = 1'b0;
      rom_addr_i    = 32'd0;
      ld_start      = 1'b0;
      ld_addr_i     = 10'd0;
      ld_byte_valid = 1'b0;
      ld_byte       = 8'd0;
      ld_end        = 1'b0;
      foreach (known[i]) known[i] = 1'b0;
      test_reset();
      test_load();
      test_partial();
      test_wrap();
      test_fetch_gating();
      test_reset_midload();
      test_collision();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
